delay_timer: RTL and testbench
==============================

Name: delay_timer

Overview:
- Parametrised successor of the single-shot millisecond delay: programmable time unit, counter width, one-shot or periodic mode, pause/resume, abort and a one-cycle expiry pulse.
- Feeds game-tick, debounce and animation timing logic.
- Consumers either poll busy/free or react to the done strobe.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz; must be a multiple of 1_000_000
UNIT_US, 1000, length of one count unit in microseconds (1000 = ms)
COUNT_W, 16, width of the period/remaining count
Derived: T = (CLK_HZ/1_000_000)*UNIT_US clock cycles per unit; T >= 2 required; prescaler width = clog2(T)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
set  in  1  start/restart strobe; samples period and periodic
stop  in  1  abort strobe; returns to idle without done
pause  in  1  level; while high in RUN, all counters hold
periodic  in  1  mode sampled with set: 0 one-shot, 1 auto-reload
period  in  COUNT_W  delay length in units, sampled with set
busy  out  1  high while a run is active (including paused)
free  out  1  ~busy
done  out  1  one-cycle pulse at each expiry
remaining  out  COUNT_W  units left including the current one; 0 when idle

Behaviour:
- Registered state: run flag, mode_r, period_r, unit_cnt (COUNT_W), presc (clog2(T)), done. All outputs are registered or a direct function of registers.
- Reset: busy=0, free=1, done=0, remaining=0. period_r, mode_r and presc are cleared.
- Priority per edge: rst > stop > set > pause > counting.
- done defaults to 0 every edge unless an expiry occurs on that edge.
- stop: run=0, unit_cnt=0, done=0. This applies even if the run would have expired on this edge. A stop while idle has no effect.
- set with period=N>0: load period_r=N, mode_r=periodic, unit_cnt=N, presc=T-1, run=1. busy is high from the next cycle. A set while busy restarts with the new values; the aborted run never produces done. A set on the same edge as an expiry wins, and no done is produced.
- set with period=0, either mode: run stays/becomes 0 and done=1 for exactly one cycle after the set edge. Any active run is cancelled.
- Counting (run=1, pause=0), per edge:
  - presc>0: presc decrements.
  - presc=0 and unit_cnt>1: unit_cnt decrements and presc reloads to T-1.
  - presc=0 and unit_cnt=1: expiry. done=1.
    - One-shot: run=0, unit_cnt=0.
    - Periodic: unit_cnt=period_r, presc=T-1, run stays 1.
- Timing: with set at edge 0 and no pause, expiry occurs at edge N*T. done is high in the cycle after edge N*T. In one-shot mode busy is high for exactly N*T cycles. In periodic mode done pulses every N*T cycles thereafter.
- pause: holds presc and unit_cnt and suppresses expiry. Each paused cycle extends the run by exactly one cycle. pause while idle is ignored. set/stop act normally while paused.
- remaining = unit_cnt. It decrements once per unit and shows N immediately after set.
- Width: N up to 2^COUNT_W-1. No wrap can occur, because a counter never decrements from 0.

Test Plan (CLK_HZ=1_000_000, UNIT_US=4 -> T=4, COUNT_W=8):
- One-shot: set at edge 0 with period=3, periodic=0 -> busy high for 12 cycles; remaining 3,2,1 changing every 4 cycles; done high exactly in the cycle after edge 12; free=1 afterwards.
- Periodic: set with period=2, periodic=1 -> done pulses after edges 8, 16, 24, ...; busy stays 1; a stop at edge 18 yields no further done, busy=0 and remaining=0.
- Pause: period=2 one-shot, pause high for 5 cycles starting at edge 3 -> done after edge 13; remaining frozen during the pause.
- Restart/collision: period=5 run restarted with period=1 at edge 7 -> single done after edge 11. A set coinciding with an expiry edge -> no done on that edge and a fresh run starts.
- Zero period and reset: set with period=0 -> done for 1 cycle, busy never rises. rst asserted mid-run -> next cycle busy=0, done=0, remaining=0, and no done follows.

Source files
------------

// File: rtl/delay_timer.sv
// Programmable delay timer: counts `period` units of T clock cycles each, one-shot or
// auto-reload, with pause, abort and a one-cycle done strobe at every expiry.
module delay_timer #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned UNIT_US = 1000,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_set,
    input  logic               i_stop,
    input  logic               i_pause,
    input  logic               i_periodic,
    input  logic [COUNT_W-1:0] i_period,
    output logic               o_busy,
    output logic               o_free,
    output logic               o_done,
    output logic [COUNT_W-1:0] o_remaining
);

    localparam int unsigned T  = (CLK_HZ / 1_000_000) * UNIT_US;
    localparam int unsigned PW = $clog2(T);
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(T - 1);

    logic               r_run;
    logic               r_mode;
    logic [COUNT_W-1:0] r_period;
    logic [COUNT_W-1:0] r_unit_cnt;
    logic [PW-1:0]      r_presc;
    logic               r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run      <= 1'b0;
            r_mode     <= 1'b0;
            r_period   <= '0;
            r_unit_cnt <= '0;
            r_presc    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Stop also wins over an expiry on the same edge; harmless while idle.
            if (i_stop) begin
                r_run      <= 1'b0;
                r_unit_cnt <= '0;
            end else if (i_set) begin
                if (i_period == '0) begin
                    r_run      <= 1'b0;
                    r_unit_cnt <= '0;
                    r_done     <= 1'b1;
                end else begin
                    r_run      <= 1'b1;
                    r_mode     <= i_periodic;
                    r_period   <= i_period;
                    r_unit_cnt <= i_period;
                    r_presc    <= PRESC_RELOAD;
                end
            end else if (r_run && !i_pause) begin
                if (r_presc != '0) begin
                    r_presc <= r_presc - 1'b1;
                end else if (r_unit_cnt > COUNT_W'(1)) begin
                    r_unit_cnt <= r_unit_cnt - 1'b1;
                    r_presc    <= PRESC_RELOAD;
                end else begin
                    r_done <= 1'b1;
                    if (r_mode) begin
                        r_unit_cnt <= r_period;
                        r_presc    <= PRESC_RELOAD;
                    end else begin
                        r_run      <= 1'b0;
                        r_unit_cnt <= '0;
                    end
                end
            end
        end
    end

    assign o_busy      = r_run;
    assign o_free      = ~r_run;
    assign o_done      = r_done;
    assign o_remaining = r_unit_cnt;

endmodule

// File: tb/tb_delay_timer.sv
// Bench for delay_timer: directed scenarios plus random traffic, every cycle checked
// against an elapsed-time model of the timer.
module tb_delay_timer;

    localparam int unsigned CLK_HZ  = 1_000_000;
    localparam int unsigned UNIT_US = 4;
    localparam int unsigned COUNT_W = 8;
    localparam int          T       = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               set = 1'b0;
    logic               stop = 1'b0;
    logic               pause = 1'b0;
    logic               periodic = 1'b0;
    logic [COUNT_W-1:0] period = '0;
    logic               busy;
    logic               free;
    logic               done;
    logic [COUNT_W-1:0] remaining;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a run is "n units, elapsed active cycles so far".
    bit m_active = 1'b0;
    bit m_per = 1'b0;
    int m_n = 0;
    int m_elapsed = 0;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    delay_timer #(
        .CLK_HZ (CLK_HZ),
        .UNIT_US(UNIT_US),
        .COUNT_W(COUNT_W)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_set      (set),
        .i_stop     (stop),
        .i_pause    (pause),
        .i_periodic (periodic),
        .i_period   (period),
        .o_busy     (busy),
        .o_free     (free),
        .o_done     (done),
        .o_remaining(remaining)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (rst) begin
            m_active  = 1'b0;
            m_elapsed = 0;
            m_n       = 0;
        end else if (stop) begin
            m_active = 1'b0;
        end else if (set) begin
            if (period == 0) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end else begin
                m_active  = 1'b1;
                m_per     = periodic;
                m_n       = int'(period);
                m_elapsed = 0;
            end
        end else if (m_active && !pause) begin
            m_elapsed++;
            if (m_elapsed == m_n * T) begin
                m_done = 1'b1;
                if (m_per) m_elapsed = 0;
                else m_active = 1'b0;
            end
        end
    endtask

    // One clock: drive inputs away from the edge, advance the model, check after the edge.
    task automatic cyc(input logic a_rst, input logic a_stop, input logic a_set,
                       input logic a_pause, input logic a_per, input int a_period);
        @(negedge clk);
        rst      = a_rst;
        stop     = a_stop;
        set      = a_set;
        pause    = a_pause;
        periodic = a_per;
        period   = COUNT_W'(a_period);
        model_step();
        @(posedge clk);
        #1;
        check("busy", int'(busy), int'(m_active));
        check("free", int'(free), int'(!m_active));
        check("done", int'(done), int'(m_done));
        check("remaining", int'(remaining), m_active ? (m_n - m_elapsed / T) : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_edge;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("rst_busy", int'(busy), 0);
        check("rst_free", int'(free), 1);
        check("rst_remaining", int'(remaining), 0);
        idle(3);

        // One-shot, period 3: busy for 12 cycles, done after edge 12
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        check("oneshot_rem_after_set", int'(remaining), 3);
        busy_cnt = 1;
        done_edge = -1;
        for (int e = 1; e <= 20; e++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            if (busy) busy_cnt++;
            if (done) done_edge = e;
            if (e == 4) check("oneshot_rem_e4", int'(remaining), 2);
            if (e == 8) check("oneshot_rem_e8", int'(remaining), 1);
        end
        check("oneshot_busy_len", busy_cnt, 12);
        check("oneshot_done_edge", done_edge, 12);
        check("oneshot_free_after", int'(free), 1);

        // Periodic, period 2: done after edges 8 and 16, stop at edge 18
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        done_cnt = 0;
        for (int e = 1; e <= 17; e++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            if (done) done_cnt++;
            if (e == 8 || e == 16) check("periodic_done_edge", int'(done), 1);
        end
        check("periodic_done_cnt", done_cnt, 2);
        check("periodic_busy", int'(busy), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        done_cnt = 0;
        for (int e = 19; e <= 30; e++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            if (done) done_cnt++;
        end
        check("stop_no_done", done_cnt, 0);
        check("stop_busy", int'(busy), 0);
        check("stop_remaining", int'(remaining), 0);

        // Pause for edges 3..7 on a period-2 one-shot: done after edge 13
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        done_edge = -1;
        for (int e = 1; e <= 20; e++) begin
            cyc(1'b0, 1'b0, 1'b0, (e >= 3 && e <= 7), 1'b0, 0);
            if (done) done_edge = e;
        end
        check("pause_done_edge", done_edge, 13);

        // Restart period 5 with period 1 at edge 7: single done after edge 11
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        done_cnt = 0;
        done_edge = -1;
        for (int e = 1; e <= 30; e++) begin
            cyc(1'b0, 1'b0, (e == 7), 1'b0, 1'b0, (e == 7) ? 1 : 0);
            if (done) begin done_cnt++; done_edge = e; end
        end
        check("restart_done_cnt", done_cnt, 1);
        check("restart_done_edge", done_edge, 11);

        // Set on the expiry edge (edge 4 of a period-1 run): only the fresh run's done
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        done_cnt = 0;
        done_edge = -1;
        for (int e = 1; e <= 20; e++) begin
            cyc(1'b0, 1'b0, (e == 4), 1'b0, 1'b0, (e == 4) ? 2 : 0);
            if (done) begin done_cnt++; done_edge = e; end
        end
        check("collide_done_cnt", done_cnt, 1);
        check("collide_done_edge", done_edge, 12);

        // Zero period: one done, never busy
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        check("zero_done", int'(done), 1);
        busy_cnt = int'(busy);
        done_cnt = 0;
        for (int e = 1; e <= 8; e++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("zero_busy_cnt", busy_cnt, 0);
        check("zero_done_once", done_cnt, 0);

        // Reset mid-run
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        idle(4);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_remaining", int'(remaining), 0);
        done_cnt = 0;
        for (int e = 1; e <= 20; e++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            if (done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic r_rst, r_stop, r_set, r_pause, r_per;
            int   r_period;
            r_rst    = ($urandom_range(0, 399) == 0);
            r_stop   = ($urandom_range(0, 99) == 0);
            r_set    = ($urandom_range(0, 39) == 0);
            r_pause  = ($urandom_range(0, 4) == 0);
            r_per    = $urandom_range(0, 1) == 1;
            r_period = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                                   : int'($urandom_range(0, 6));
            cyc(r_rst, r_stop, r_set, r_pause, r_per, r_period);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
